// File: rtl/mult_pkg.sv
// Shared types, default widths and saturation-limit helper for the multiply-accumulate block.
package mult_pkg;

  localparam int IN_WIDTH_DEF  = 16;
  localparam int ACC_WIDTH_DEF = 40;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
  } sat_lim_t;

  // Largest and smallest two's-complement values representable in `width` bits (width <= 64).
  function automatic sat_lim_t sat_limits(input int unsigned width);
    sat_lim_t lim;
    lim.min_v = -(64'sd1 <<< (width - 32'd1));
    lim.max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    return lim;
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Signed accumulator adder with overflow detection; clamps on overflow when ACC_SAT_EN is defined,
// otherwise wraps modulo 2^ACC_WIDTH.
module acc_sat_add
  import mult_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH-1:0] raw_s;
  logic                 ovf_s;

  assign raw_s = a_i + b_i;
  // Overflow only when both operands share a sign and the result's sign differs.
  assign ovf_s = (a_i[ACC_WIDTH-1] == b_i[ACC_WIDTH-1]) && (raw_s[ACC_WIDTH-1] != a_i[ACC_WIDTH-1]);
  assign ovf_o = ovf_s;

`ifdef ACC_SAT_EN
  localparam sat_lim_t             LIM     = sat_limits(ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = LIM.max_v[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = LIM.min_v[ACC_WIDTH-1:0];

  // Clamp toward the sign of the operands on overflow.
  always_comb begin
    sum_o = raw_s;
    if (!ovf_s) begin
      sum_o = raw_s;
    end else if (a_i[ACC_WIDTH-1]) begin
      sum_o = ACC_MIN;
    end else begin
      sum_o = ACC_MAX;
    end
  end
`else
  assign sum_o = raw_s;
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Accumulates a stream of signed products into one sum per in_last-terminated packet.
// Optional ACC_SAT_EN macro selects saturating instead of wrapping accumulation.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int PROD_WIDTH = 2 * IN_WIDTH,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf
);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 xfer_s;
  logic [ACC_WIDTH-1:0] prod_ext_s;
  logic [ACC_WIDTH-1:0] sum_s;
  logic                 add_ovf_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic                 ovf_nxt_s;

  assign xfer_s     = in_valid && in_ready_q;
  assign prod_ext_s = ACC_WIDTH'($signed(in_prod));
  assign cnt_inc_s  = cnt_q + CNT_WIDTH'(1);
  assign ovf_nxt_s  = ovf_q | add_ovf_s;

  acc_sat_add #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc_sat_add (
    .a_i   (acc_q),
    .b_i   (prod_ext_s),
    .sum_o (sum_s),
    .ovf_o (add_ovf_s)
  );

  // Next-state, accumulator and result-register logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer_s) begin
          acc_d = sum_s;
          cnt_d = cnt_inc_s;
          ovf_d = ovf_nxt_s;
          if (in_last) begin
            out_valid_d = 1'b1;
            out_acc_d   = sum_s;
            out_count_d = cnt_inc_s;
            out_ovf_d   = ovf_nxt_s;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        // Result registers stay frozen until the consumer takes them.
        if (out_valid_q && out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          out_acc_d   = '0;
          out_count_d = '0;
          out_ovf_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
        out_acc_d   = '0;
        out_count_d = '0;
        out_ovf_d   = 1'b0;
        state_d     = IDLE;
      end
    endcase
    in_ready_d = (state_d != HOLD);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed and randomized bench for mult_accumulator at IN_WIDTH=4, PROD_WIDTH=8, ACC_WIDTH=10.
module tb_mult_accumulator;

  localparam int IW = 4;
  localparam int PW = 8;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam longint ACC_MAX_V = 511;
  localparam longint ACC_MIN_V = -512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_prod = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_acc;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_accumulator #(
    .IN_WIDTH   (IW),
    .PROD_WIDTH (PW),
    .ACC_WIDTH  (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint acc_val();
    return longint'($signed(out_acc));
  endfunction

  // Reference: integer running sum, flagging and then wrapping or clamping out-of-range results.
  function automatic void model(input int beats[$], output longint acc, output longint cnt,
                                output longint ovf);
    acc = 0;
    ovf = 0;
    foreach (beats[i]) begin
      acc = acc + beats[i];
      if (acc > ACC_MAX_V) begin
        ovf = 1;
`ifdef ACC_SAT_EN
        acc = ACC_MAX_V;
`else
        acc = acc - 1024;
`endif
      end else if (acc < ACC_MIN_V) begin
        ovf = 1;
`ifdef ACC_SAT_EN
        acc = ACC_MIN_V;
`else
        acc = acc + 1024;
`endif
      end
    end
    cnt = beats.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = p[PW-1:0];
    in_last  = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_prod  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic expect_result(input string tag, input longint acc, input longint cnt,
                               input longint ovf);
    check({tag, "_valid"}, longint'(out_valid), 1);
    check({tag, "_in_ready"}, longint'(in_ready), 0);
    check({tag, "_acc"}, acc_val(), acc);
    check({tag, "_count"}, longint'(out_count), cnt);
    check({tag, "_ovf"}, longint'(out_ovf), ovf);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_acc_valid_low"}, longint'(out_valid), 0);
    check({tag, "_acc_in_ready"}, longint'(in_ready), 1);
    check({tag, "_acc_zero"}, acc_val(), 0);
    check({tag, "_acc_cnt_zero"}, longint'(out_count), 0);
  endtask

  initial begin
    int q[$];
    longint e_acc, e_cnt, e_ovf;
    int n, p;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_acc", acc_val(), 0);
    check("rst_count", longint'(out_count), 0);
    check("rst_ovf", longint'(out_ovf), 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    check("rst_rel_in_ready_before_edge", longint'(in_ready), 0);
    tick();
    check("rst_rel_in_ready", longint'(in_ready), 1);

    // Basic sum with latency check
    send(21, 1'b0);
    send(-21, 1'b0);
    check("sum_valid_early", longint'(out_valid), 0);
    send(49, 1'b1);
    expect_result("sum", 49, 3, 0);
    accept("sum");

    // Single beat with backpressure
    send(-49, 1'b1);
    expect_result("single", -49, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_acc", acc_val(), -49);
      check("bp_count", longint'(out_count), 1);
    end
    accept("bp");

    // Overflow: eleven beats of 49
    for (int i = 0; i < 11; i++) send(49, i == 10);
`ifdef ACC_SAT_EN
    expect_result("ovf", 511, 11, 1);
`else
    expect_result("ovf", -485, 11, 1);
`endif
    accept("ovf");

    // Reset mid-operation discards partial sum
    send(7, 1'b0);
    send(9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_valid", longint'(out_valid), 0);
    check("midrst_acc", acc_val(), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("midrst_rel_in_ready", longint'(in_ready), 1);
    send(3, 1'b1);
    expect_result("midrst", 3, 1, 0);
    accept("midrst");

    // Gaps: in_valid low between beats with junk on in_prod/in_last
    send(1, 1'b0);
    in_prod = 8'd99;
    in_last = 1'b1;
    tick();
    send(2, 1'b0);
    in_prod = 8'd77;
    in_last = 1'b1;
    tick();
    send(3, 1'b1);
    expect_result("gaps", 6, 3, 0);
    accept("gaps");

    // Randomized packets against the reference model
    for (int t = 0; t < 40; t++) begin
      q.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        p = int'($urandom_range(0, 255)) - 128;
        q.push_back(p);
        send(p, i == n - 1);
        if (i != n - 1 && $urandom_range(0, 2) == 0) tick();
      end
      model(q, e_acc, e_cnt, e_ovf);
      expect_result("rand", e_acc, e_cnt, e_ovf);
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        tick();
        check("rand_hold_acc", acc_val(), e_acc);
      end
      accept("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
